spi_frame_rx: RTL and testbench



---
 rtl/spi_frame_rx.sv | 93 +++++++++
 tb/tb_spi_frame_rx.sv | 119 +++++++++++
 2 files changed

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI mode-0 receiver that turns each 16-bit chip-select frame into one parallel command.
// Optional malformed-frame strobe enabled by defining SPI_FRAME_ERR_EN.
module spi_frame_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       n_cs,
    output logic       read_write,
    output logic [6:0] addr,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);
    typedef enum logic {IDLE, SHIFT} state_e;
    state_e state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, cs_sync_q;
    logic        sclk_hist_q, cs_hist_q;
    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d, valid_q, valid_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        sclk_s, copi_s, cs_s, sclk_rise, cs_rise, cs_fall;
    logic        shift_en, frame_end, frame_ok;
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], n_cs};
            sclk_hist_q <= sclk_s;
            cs_hist_q   <= cs_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end
    // A chip-select rise wins over a coincident sclk edge, so the frame is judged on the current count.
    always_comb begin
        state_d  = (state_q == IDLE) ? (cs_fall ? SHIFT : IDLE) : (cs_rise ? IDLE : SHIFT);
        shift_en = (state_q == SHIFT) && !cs_rise && sclk_rise;
        shreg_d  = shift_en ? {shreg_q[14:0], copi_s} : shreg_q;
        cnt_d    = (state_d == IDLE) ? 5'd0 :
                   shift_en ? ((cnt_q == 5'd17) ? 5'd17 : cnt_q + 5'd1) : cnt_q;
    end
    always_comb begin
        frame_end = (state_q == SHIFT) && cs_rise;
        frame_ok  = frame_end && (cnt_q == 5'd16);
        valid_d   = frame_ok;
        rw_d      = frame_ok ? shreg_q[15]   : rw_q;
        addr_d    = frame_ok ? shreg_q[14:8] : addr_q;
        data_d    = frame_ok ? shreg_q[7:0]  : data_q;
    end
    assign read_write = rw_q;
    assign addr       = addr_q;
    assign data       = data_q;
    assign valid      = valid_q;
`ifdef SPI_FRAME_ERR_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= frame_end && (cnt_q != 5'd16);
    end
    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: randomized frame stimulus for spi_frame_rx checked against a frame-level reference model.
module tb_spi_frame_rx;
`ifdef SPI_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n, sclk, copi, n_cs;
    logic read_write, valid, frame_err;
    logic [6:0] addr;
    logic [7:0] data;
    int n_cmp = 0, n_err = 0, n_valid = 0, n_ferr = 0, exp_valid = 0, exp_ferr = 0;
    logic [15:0] exp_fields = '0;
    int lens [7] = '{16, 16, 16, 0, 15, 17, 20};

    spi_frame_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .n_cs(n_cs),
        .read_write(read_write), .addr(addr), .data(data), .valid(valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (frame_err) n_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic shift_bits(input int n, input logic [31:0] val);
        int hp;
        for (int i = n - 1; i >= 0; i--) begin
            hp = int'($urandom_range(3, 6));
            copi = val[i];
            repeat (hp) @(negedge clk);
            sclk = 1'b1;
            repeat (hp) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // Only an exactly-16-bit frame updates the fields; anything else is malformed.
    task automatic send_frame(input int n, input logic [31:0] val);
        logic bad;
        bad = (n != 16);
        n_cs = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(n, val);
        repeat (3) @(negedge clk);
        n_cs = 1'b1;
        if (!bad) begin
            exp_fields = val[15:0];
            exp_valid++;
        end else if (ERR_EN) exp_ferr++;
        repeat (2) @(negedge clk);
        check("early_strobe", 32'({valid, frame_err}), 32'd0);
        @(negedge clk);
        check("valid", 32'(valid), 32'(!bad));
        check("frame_err", 32'(frame_err), 32'(ERR_EN && bad));
        check("fields", 32'({read_write, addr, data}), 32'(exp_fields));
    endtask

    initial begin
        rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; n_cs = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_fields", 32'({read_write, addr, data}), 32'd0);
        check("rst_strobes", 32'({valid, frame_err}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(16, 32'h8055);
        send_frame(16, 32'h03F0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_hold", 32'({valid, read_write, addr, data}), 32'(exp_fields));
        end
        send_frame(15, $urandom);
        send_frame(17, $urandom);
        n_cs = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(8, $urandom);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_fields", 32'({read_write, addr, data}), 32'd0);
        check("midrst_strobes", 32'({valid, frame_err}), 32'd0);
        n_cs = 1'b1; sclk = 1'b0;
        exp_fields = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(16, 32'h8102);
        repeat (16) begin
            copi = 1'($urandom);
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        send_frame(16, 32'h8422);
        send_frame(16, 32'h8011);
        send_frame(16, 32'h8122);
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_frame(lens[$urandom_range(0, 6)], $urandom);
        end
        repeat (10) @(negedge clk);
        check("valid_count", 32'(n_valid), 32'(exp_valid));
        check("err_count", 32'(n_ferr), 32'(exp_ferr));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
